cal_sample_averager: RTL and testbench

Upstream stage of the calibration debug UART emitter.
- Boxcar-averages each of the 4 ADC channels over 2^LOG2_N codec samples.
- Presents the averages as a tear-free snapshot that changes only on a frame-start request from the UART emitter.
- Used for board bringup and calibration only.

---
 rtl/cal_pkg.sv | 11 +
 rtl/cal_sample_averager_if.sv | 40 ++++
 rtl/cal_avg_channel.sv | 69 ++++++
 rtl/cal_sample_averager.sv | 127 ++++++++++++
 tb/tb_cal_sample_averager.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/cal_pkg.sv
// Shared constants and helpers for the calibration sample averager.
package cal_pkg;

    localparam int NUM_CH = 4;

    // Sum of 2^log2_n samples of w bits never exceeds w + log2_n signed bits.
    function automatic int acc_w(input int w, input int log2_n);
        return w + log2_n;
    endfunction

endpackage

// File: rtl/cal_sample_averager_if.sv
// Sample/snapshot bus of the calibration averager; CAL_AVG_PEAK_EN adds ptp0..ptp3.
interface cal_sample_averager_if #(
    parameter int W = 16
);
    logic                sample_valid;
    logic signed [W-1:0] adc0;
    logic signed [W-1:0] adc1;
    logic signed [W-1:0] adc2;
    logic signed [W-1:0] adc3;
    logic                snap_req;
    logic signed [W-1:0] avg0;
    logic signed [W-1:0] avg1;
    logic signed [W-1:0] avg2;
    logic signed [W-1:0] avg3;
    logic                snap_fresh;
    logic [7:0]          blocks;
`ifdef CAL_AVG_PEAK_EN
    logic [W-1:0]        ptp0;
    logic [W-1:0]        ptp1;
    logic [W-1:0]        ptp2;
    logic [W-1:0]        ptp3;
`endif

    modport master (
        output sample_valid, adc0, adc1, adc2, adc3, snap_req,
`ifdef CAL_AVG_PEAK_EN
        input  ptp0, ptp1, ptp2, ptp3,
`endif
        input  avg0, avg1, avg2, avg3, snap_fresh, blocks
    );

    modport slave (
        input  sample_valid, adc0, adc1, adc2, adc3, snap_req,
`ifdef CAL_AVG_PEAK_EN
        output ptp0, ptp1, ptp2, ptp3,
`endif
        output avg0, avg1, avg2, avg3, snap_fresh, blocks
    );

endinterface

// File: rtl/cal_avg_channel.sv
// One channel: boxcar accumulator with block-end shift; CAL_AVG_PEAK_EN adds max/min tracking.
module cal_avg_channel
    import cal_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    input  logic                i_last,
`ifdef CAL_AVG_PEAK_EN
    input  logic                i_first,
    output logic [W-1:0]        o_ptp,
`endif
    input  logic signed [W-1:0] i_adc,
    output logic signed [W-1:0] o_avg
);

    localparam int ACC_W = acc_w(W, LOG2_N);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_sum;

    // Arithmetic shift floors toward -inf; the result always fits in W bits.
    function automatic logic signed [W-1:0] blk_avg(input logic signed [ACC_W-1:0] s);
        return W'(s >>> LOG2_N);
    endfunction

    assign w_sum = r_acc + ACC_W'(i_adc);
    assign o_avg = blk_avg(w_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_valid) begin
            r_acc <= i_last ? '0 : w_sum;
        end
    end

`ifdef CAL_AVG_PEAK_EN
    logic signed [W-1:0] r_max;
    logic signed [W-1:0] r_min;
    logic signed [W-1:0] w_max;
    logic signed [W-1:0] w_min;

    function automatic logic [W-1:0] sat_ptp(input logic signed [W-1:0] hi,
                                             input logic signed [W-1:0] lo);
        logic signed [W:0] d;
        d = {hi[W-1], hi} - {lo[W-1], lo};
        return d[W] ? {W{1'b1}} : d[W-1:0];
    endfunction

    assign w_max = (i_first || i_adc > r_max) ? i_adc : r_max;
    assign w_min = (i_first || i_adc < r_min) ? i_adc : r_min;
    assign o_ptp = sat_ptp(w_max, w_min);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
            r_min <= '0;
        end else if (i_valid) begin
            r_max <= w_max;
            r_min <= w_min;
        end
    end
`endif

endmodule

// File: rtl/cal_sample_averager.sv
// Four-channel block averager with tear-free snapshot on snap_req; CAL_AVG_PEAK_EN adds peak-to-peak.
module cal_sample_averager
    import cal_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 4
) (
    input  logic            clk,
    input  logic            rst,
    cal_sample_averager_if.slave bus
);

    localparam int N     = 1 << LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;

    typedef struct packed {
        logic signed [W-1:0] avg;
`ifdef CAL_AVG_PEAK_EN
        logic [W-1:0]        ptp;
`endif
    } snap_t;

    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_blocks;
    logic                r_pend_fresh;
    logic                r_snap_fresh;
    snap_t               r_pend [NUM_CH];
    snap_t               r_snap [NUM_CH];
    snap_t               w_res  [NUM_CH];
    logic signed [W-1:0] w_adc  [NUM_CH];
    logic signed [W-1:0] w_avg  [NUM_CH];
    logic                w_last;
    logic                w_blk_end;

    assign w_adc[0]  = bus.adc0;
    assign w_adc[1]  = bus.adc1;
    assign w_adc[2]  = bus.adc2;
    assign w_adc[3]  = bus.adc3;
    assign w_last    = (r_cnt == CNT_W'(N - 1));
    assign w_blk_end = bus.sample_valid & w_last;

`ifdef CAL_AVG_PEAK_EN
    logic [W-1:0] w_ptp [NUM_CH];
    logic         w_first;
    assign w_first = (r_cnt == '0);
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        cal_avg_channel #(
            .W      (W),
            .LOG2_N (LOG2_N)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_valid (bus.sample_valid),
            .i_last  (w_last),
`ifdef CAL_AVG_PEAK_EN
            .i_first (w_first),
            .o_ptp   (w_ptp[g]),
`endif
            .i_adc   (w_adc[g]),
            .o_avg   (w_avg[g])
        );
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_res[i]     = '0;
            w_res[i].avg = w_avg[i];
`ifdef CAL_AVG_PEAK_EN
            w_res[i].ptp = w_ptp[i];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_blocks     <= '0;
            r_pend_fresh <= 1'b0;
            r_snap_fresh <= 1'b0;
        end else begin
            if (bus.sample_valid) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_blk_end) begin
                r_blocks     <= r_blocks + 8'd1;
                r_pend_fresh <= 1'b1;
            end
            // A snapshot consumes freshness, even one completing this very cycle.
            if (bus.snap_req) begin
                r_snap_fresh <= w_blk_end | r_pend_fresh;
                r_pend_fresh <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                r_pend[i] <= '0;
                r_snap[i] <= '0;
            end else begin
                if (w_blk_end) begin
                    r_pend[i] <= w_res[i];
                end
                if (bus.snap_req) begin
                    r_snap[i] <= w_blk_end ? w_res[i] : r_pend[i];
                end
            end
        end
    end

    assign bus.avg0       = r_snap[0].avg;
    assign bus.avg1       = r_snap[1].avg;
    assign bus.avg2       = r_snap[2].avg;
    assign bus.avg3       = r_snap[3].avg;
    assign bus.snap_fresh = r_snap_fresh;
    assign bus.blocks     = r_blocks;
`ifdef CAL_AVG_PEAK_EN
    assign bus.ptp0       = r_snap[0].ptp;
    assign bus.ptp1       = r_snap[1].ptp;
    assign bus.ptp2       = r_snap[2].ptp;
    assign bus.ptp3       = r_snap[3].ptp;
`endif

endmodule

// File: tb/tb_cal_sample_averager.sv
// Directed bench for cal_sample_averager (W=16, LOG2_N=4); CAL_AVG_PEAK_EN enables ptp scenarios.
module tb_cal_sample_averager;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    cal_sample_averager_if #(.W(16)) bus ();

    cal_sample_averager #(
        .W      (16),
        .LOG2_N (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // adc0: sample 0 = a0_first, then even/odd indices alternate a0_even/a0_odd.
    task automatic block(input int n, input logic signed [15:0] a0_first,
                         input logic signed [15:0] a0_even, input logic signed [15:0] a0_odd,
                         input logic signed [15:0] a1, input logic signed [15:0] a2,
                         input logic signed [15:0] a3, input bit snap_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.sample_valid = 1'b1;
            bus.adc0 = (i == 0) ? a0_first : ((i % 2 == 0) ? a0_even : a0_odd);
            bus.adc1 = a1;
            bus.adc2 = a2;
            bus.adc3 = a3;
            bus.snap_req = snap_last && (i == n - 1);
        end
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.snap_req = 1'b0;
    endtask

    task automatic snap();
        @(negedge clk);
        bus.snap_req = 1'b1;
        @(negedge clk);
        bus.snap_req = 1'b0;
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        pulse_rst();
        n_vec++; if (bus.avg0 !== 16'sd0) begin n_err++; $display("FAIL reset_avg0 got=%0d exp=0", bus.avg0); end
        n_vec++; if (bus.avg3 !== 16'sd0) begin n_err++; $display("FAIL reset_avg3 got=%0d exp=0", bus.avg3); end
        n_vec++; if (bus.snap_fresh !== 1'b0) begin n_err++; $display("FAIL reset_fresh got=%0b exp=0", bus.snap_fresh); end
        n_vec++; if (bus.blocks !== 8'd0) begin n_err++; $display("FAIL reset_blocks got=%0d exp=0", bus.blocks); end
`ifdef CAL_AVG_PEAK_EN
        n_vec++; if (bus.ptp0 !== 16'd0) begin n_err++; $display("FAIL reset_ptp0 got=%0d exp=0", bus.ptp0); end
`endif
    endtask

    task automatic test_basic();
        block(16, 16'sd100, 16'sd100, 16'sd100, -16'sd100, 16'sd0, 16'sd32767, 1'b0);
        n_vec++; if (bus.blocks !== 8'd1) begin n_err++; $display("FAIL basic_blocks_pre got=%0d exp=1", bus.blocks); end
        n_vec++; if (bus.avg0 !== 16'sd0) begin n_err++; $display("FAIL basic_avg0_held got=%0d exp=0", bus.avg0); end
        snap();
        n_vec++; if (bus.avg0 !== 16'sd100) begin n_err++; $display("FAIL basic_avg0 got=%0d exp=100", bus.avg0); end
        n_vec++; if (bus.avg1 !== -16'sd100) begin n_err++; $display("FAIL basic_avg1 got=%0d exp=-100", bus.avg1); end
        n_vec++; if (bus.avg2 !== 16'sd0) begin n_err++; $display("FAIL basic_avg2 got=%0d exp=0", bus.avg2); end
        n_vec++; if (bus.avg3 !== 16'sd32767) begin n_err++; $display("FAIL basic_avg3 got=%0d exp=32767", bus.avg3); end
        n_vec++; if (bus.snap_fresh !== 1'b1) begin n_err++; $display("FAIL basic_fresh got=%0b exp=1", bus.snap_fresh); end
        n_vec++; if (bus.blocks !== 8'd1) begin n_err++; $display("FAIL basic_blocks got=%0d exp=1", bus.blocks); end
    endtask

    task automatic test_truncation();
        block(16, -16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        snap();
        n_vec++; if (bus.avg0 !== -16'sd1) begin n_err++; $display("FAIL trunc_neg_avg0 got=%0d exp=-1", bus.avg0); end
        n_vec++; if (bus.blocks !== 8'd2) begin n_err++; $display("FAIL trunc_blocks got=%0d exp=2", bus.blocks); end
        block(16, 16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        snap();
        n_vec++; if (bus.avg0 !== 16'sd0) begin n_err++; $display("FAIL trunc_pos_avg0 got=%0d exp=0", bus.avg0); end
    endtask

    task automatic test_double_snap();
        block(16, 16'sd7, 16'sd7, 16'sd7, 16'sd8, 16'sd9, -16'sd10, 1'b0);
        snap();
        n_vec++; if (bus.avg0 !== 16'sd7) begin n_err++; $display("FAIL dbl_first_avg0 got=%0d exp=7", bus.avg0); end
        n_vec++; if (bus.snap_fresh !== 1'b1) begin n_err++; $display("FAIL dbl_first_fresh got=%0b exp=1", bus.snap_fresh); end
        snap();
        n_vec++; if (bus.avg0 !== 16'sd7) begin n_err++; $display("FAIL dbl_second_avg0 got=%0d exp=7", bus.avg0); end
        n_vec++; if (bus.avg3 !== -16'sd10) begin n_err++; $display("FAIL dbl_second_avg3 got=%0d exp=-10", bus.avg3); end
        n_vec++; if (bus.snap_fresh !== 1'b0) begin n_err++; $display("FAIL dbl_second_fresh got=%0b exp=0", bus.snap_fresh); end
    endtask

    task automatic test_back_to_back();
        block(16, 16'sd500, 16'sd500, 16'sd500, 16'sd500, 16'sd500, 16'sd500, 1'b1);
        n_vec++; if (bus.avg0 !== 16'sd500) begin n_err++; $display("FAIL bypass_avg0 got=%0d exp=500", bus.avg0); end
        n_vec++; if (bus.snap_fresh !== 1'b1) begin n_err++; $display("FAIL bypass_fresh got=%0b exp=1", bus.snap_fresh); end
        n_vec++; if (bus.blocks !== 8'd5) begin n_err++; $display("FAIL bypass_blocks got=%0d exp=5", bus.blocks); end
        snap();
        n_vec++; if (bus.snap_fresh !== 1'b0) begin n_err++; $display("FAIL bypass_later_fresh got=%0b exp=0", bus.snap_fresh); end
        n_vec++; if (bus.avg0 !== 16'sd500) begin n_err++; $display("FAIL bypass_later_avg0 got=%0d exp=500", bus.avg0); end
    endtask

    task automatic test_rst_mid_block();
        block(7, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, 1'b0);
        pulse_rst();
        n_vec++; if (bus.blocks !== 8'd0) begin n_err++; $display("FAIL rstmid_blocks0 got=%0d exp=0", bus.blocks); end
        n_vec++; if (bus.avg0 !== 16'sd0) begin n_err++; $display("FAIL rstmid_avg0_cleared got=%0d exp=0", bus.avg0); end
        block(16, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 16'sd200, 1'b0);
        snap();
        n_vec++; if (bus.avg0 !== 16'sd200) begin n_err++; $display("FAIL rstmid_avg0 got=%0d exp=200", bus.avg0); end
        n_vec++; if (bus.blocks !== 8'd1) begin n_err++; $display("FAIL rstmid_blocks got=%0d exp=1", bus.blocks); end
    endtask

`ifdef CAL_AVG_PEAK_EN
    task automatic test_peak();
        block(16, -16'sd32768, -16'sd32768, 16'sd32767, 16'sd5, 16'sd5, 16'sd5, 1'b0);
        snap();
        n_vec++; if (bus.ptp0 !== 16'd65535) begin n_err++; $display("FAIL peak_ptp0 got=%0d exp=65535", bus.ptp0); end
        n_vec++; if (bus.ptp1 !== 16'd0) begin n_err++; $display("FAIL peak_ptp1 got=%0d exp=0", bus.ptp1); end
        n_vec++; if (bus.avg0 !== -16'sd1) begin n_err++; $display("FAIL peak_avg0 got=%0d exp=-1", bus.avg0); end
        block(16, 16'sd1234, 16'sd1234, 16'sd1234, 16'sd0, 16'sd0, 16'sd0, 1'b1);
        n_vec++; if (bus.ptp0 !== 16'd0) begin n_err++; $display("FAIL peak_const_ptp0 got=%0d exp=0", bus.ptp0); end
        block(16, 16'sd10, 16'sd3, -16'sd4, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        snap();
        n_vec++; if (bus.ptp0 !== 16'd14) begin n_err++; $display("FAIL peak_mixed_ptp0 got=%0d exp=14", bus.ptp0); end
    endtask
`endif

    initial begin
        bus.sample_valid = 1'b0;
        bus.snap_req     = 1'b0;
        bus.adc0 = '0;
        bus.adc1 = '0;
        bus.adc2 = '0;
        bus.adc3 = '0;
        test_reset();
        test_basic();
        test_truncation();
        test_double_snap();
        test_back_to_back();
        test_rst_mid_block();
`ifdef CAL_AVG_PEAK_EN
        test_peak();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
